fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the single-cycle datapath and supplies its INST word.
- Holds the program counter and requests words from a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched words in a small FIFO and hands them downstream over a valid/ready interface.
- Accepts a PC redirect (taken branch or jump, resolved from the datapath's is_Zero and control) that flushes all buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- QDEPTH, 2, instruction queue entries; power of 2, minimum 2.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word-aligned fetch address; stable while imem_req=1.
- imem_ack  input  1  memory returns data this cycle; sampled only while imem_req=1.
- imem_data  input  32  instruction word; valid when imem_ack=1.
- inst_valid  output  1  INST/pc_out hold a valid instruction.
- inst_ready  input  1  downstream consumes the head entry this cycle.
- INST  output  32  head instruction word.
- pc_out  output  32  PC of the head instruction.
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] are forced to 0 internally.

Behaviour:
- Reset (asynchronous, while RST_N=0):
  - fetch_pc=RESET_PC; state=IDLE; queue empty.
  - Outputs: imem_req=0, imem_addr=RESET_PC, inst_valid=0, INST=0, pc_out=0.
- Queue:
  - Registered FIFO of {pc, word}; count ranges 0..QDEPTH.
  - inst_valid = (count!=0); INST/pc_out show the head entry; INST=0 and pc_out=0 when empty.
  - Pop when inst_valid && inst_ready.
  - Push on an accepted ack in state REQ.
  - Simultaneous push and pop leaves count unchanged.
- State machine (registered; imem_req=1 in REQ and DROP):
  - IDLE: move to REQ when count_next<QDEPTH; imem_addr=fetch_pc.
  - REQ, no ack: hold imem_req and imem_addr.
  - REQ, ack:
    - Push {fetch_pc, imem_data}; fetch_pc += 4, wrapping 32'hFFFF_FFFC to 0.
    - Stay in REQ (back-to-back, next address the following cycle) if count_next<QDEPTH, else go to IDLE.
  - DROP: hold request at the stale address until ack; discard the data; then go to REQ at fetch_pc if count_next<QDEPTH, else IDLE.
- Slot reservation: a request starts only when a free slot exists, so an ack never arrives while the queue is full.
- Latency: minimum 1 cycle from imem_ack to inst_valid. Sustained throughput is 1 instruction per cycle when memory acks every cycle and downstream is ready.
- Redirect has the highest priority in a cycle:
  - Queue cleared (count_next=0) and fetch_pc=redirect_pc.
  - A pop in the same cycle is ignored.
  - Any ack arriving in the same cycle is discarded.
  - From REQ with no ack, go to DROP (the in-flight request must complete).
  - From REQ with ack, or from IDLE, go to REQ at redirect_pc.
  - In DROP: update fetch_pc, stay in DROP.
- Reset mid-request: imem_req drops immediately and asynchronously. The memory must treat this as an abort.
- Downstream ready=0: the queue fills, the FSM parks in IDLE, and no requests are issued.

Test Plan:
- Streaming:
  - Stimulus: reset with RESET_PC=0x100; memory acks every cycle with data=addr^0xA5A5_0000; inst_ready=1.
  - Response: inst_valid from cycle 2; pc_out=0x100,0x104,0x108…; INST matches; no gaps.
- Backpressure:
  - Stimulus: inst_ready=0 for 6 cycles.
  - Response: exactly QDEPTH entries buffered; imem_req=0 once full; on release, entries drain in order with no loss or duplication.
- Slow memory:
  - Stimulus: ack delayed 3 cycles per request.
  - Response: imem_addr stable throughout each request; one instruction delivered per ack.
- Redirect during in-flight request:
  - Stimulus: redirect=1, redirect_pc=0x2003 while REQ is waiting for ack.
  - Response: queue flushed (inst_valid=0 next cycle); stale ack discarded; next imem_addr=0x2000; first delivered pc_out=0x2000.
- Simultaneous redirect, ack and pop:
  - Response: the acked word is not pushed; the pop is ignored; the next fetch is redirect_pc.
- Wrap and reset:
  - Stimulus: fetch from 0xFFFF_FFFC.
  - Response: the next pc is 0x0.
  - Stimulus: assert RST_N=0 mid-request.
  - Response: outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit : PC, req/ack instruction fetch, {pc,word} queue, redirect flush
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] INST,
  output logic [31:0] pc_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int              PW      = $clog2(QDEPTH);
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     drop_addr_q, drop_addr_d;
  logic [31:0]     pc_mem_q   [QDEPTH];
  logic [31:0]     pc_mem_d   [QDEPTH];
  logic [31:0]     word_mem_q [QDEPTH];
  logic [31:0]     word_mem_d [QDEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            push, pop;

  assign inst_valid = (count_q != '0);
  assign INST       = inst_valid ? word_mem_q[rd_ptr_q] : 32'd0;
  assign pc_out     = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'd0;
  // Combinational from state so an async reset drops the request at once.
  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = (state_q == DROP) ? drop_addr_q : fetch_pc_q;

  always_comb begin
    pop        = inst_valid && inst_ready && !redirect;
    push       = (state_q == REQ) && imem_ack && !redirect;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pc_mem_d   = pc_mem_q;
    word_mem_d = word_mem_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = fetch_pc_q;
        word_mem_d[wr_ptr_q] = imem_data;
        wr_ptr_d             = wr_ptr_q + (PW)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (PW)'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (PW+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (PW+1)'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    case (state_q)
      IDLE: begin
        if (count_d < DEPTH_C) state_d = REQ;
      end
      REQ: begin
        if (redirect) begin
          // An unacked request must still complete; remember its address.
          if (!imem_ack) begin
            state_d     = DROP;
            drop_addr_d = fetch_pc_q;
          end
        end else if (imem_ack) begin
          state_d = (count_d < DEPTH_C) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (!redirect && imem_ack) begin
          state_d = (count_d < DEPTH_C) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    pc_mem_q   <= pc_mem_d;
    word_mem_q <= word_mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_unit : directed + random checks of fetch_unit against a stream model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          QDEPTH   = 2;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  logic        CLK, RST_N;
  logic        imem_req, imem_ack, inst_valid, inst_ready, redirect;
  logic [31:0] imem_addr, imem_data, INST, pc_out, redirect_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .INST(INST), .pc_out(pc_out),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_checks = 0, n_pass = 0, n_fail = 0;
  // Reference: the next PC the consumer should see, plus memory model state.
  logic [31:0] exp_pc;
  int          n_cons = 0, n_acks = 0;
  bit          busy, lat_rand, prev_req, prev_ack;
  int          wait_cnt, lat_fixed;
  logic [31:0] prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_clear();
    busy = 0; prev_req = 0; prev_ack = 0; imem_ack = 0; imem_data = '0;
  endtask

  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge CLK);
    if (prev_req && !prev_ack && imem_req) chk("addr_stable", imem_addr, prev_addr);
    imem_ack  = 1'b0;
    imem_data = '0;
    if (imem_req) begin
      if (!busy) begin
        busy     = 1;
        wait_cnt = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      end
      if (wait_cnt == 0) begin
        imem_ack  = 1'b1;
        imem_data = imem_addr ^ K;
        busy      = 0;
        n_acks++;
      end else begin
        wait_cnt--;
      end
    end else begin
      busy = 0;
    end
    prev_req    = imem_req;
    prev_ack    = imem_ack;
    prev_addr   = imem_addr;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (inst_valid && rdy && !redir) begin
      chk("pc_out", pc_out, exp_pc);
      chk("INST", INST, exp_pc ^ K);
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    if (redir) exp_pc = rpc & ~32'h3;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] stale;
    int          a0, c0;
    RST_N = 0; inst_ready = 0; redirect = 0; redirect_pc = '0;
    lat_rand = 0; lat_fixed = 0; wait_cnt = 0; prev_addr = '0;
    mem_clear();
    exp_pc = RESET_PC;
    repeat (2) @(negedge CLK);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", INST, 32'd0);
    chk("rst_pc", pc_out, 32'd0);

    // Streaming
    RST_N = 1;
    @(posedge CLK); #1;
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, RESET_PC);
    chk("c1_valid", {31'd0, inst_valid}, 32'd0);
    cycle(1, 0, 0);
    chk("c2_valid", {31'd0, inst_valid}, 32'd1);
    chk("c2_pc", pc_out, RESET_PC);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      chk("stream_nogap", {31'd0, inst_valid}, 32'd1);
    end

    // Backpressure
    repeat (6) cycle(0, 0, 0);
    chk("bp_req", {31'd0, imem_req}, 32'd0);
    chk("bp_valid", {31'd0, inst_valid}, 32'd1);
    chk("bp_head", pc_out, exp_pc);
    lat_fixed = 20;
    c0 = n_cons;
    for (int i = 0; i < 10; i++) begin
      if (!inst_valid) break;
      cycle(1, 0, 0);
    end
    chk("bp_buffered", 32'(n_cons - c0), 32'(QDEPTH));

    // Slow memory
    lat_fixed = 3;
    for (int i = 0; i < 40; i++) begin
      if (!inst_valid) break;
      cycle(1, 0, 0);
    end
    a0 = n_acks; c0 = n_cons;
    repeat (60) cycle(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (!inst_valid) break;
      cycle(1, 0, 0);
    end
    chk("slow_one_per_ack", 32'(n_cons - c0), 32'(n_acks - a0));

    // Redirect while a request waits for its ack
    for (int i = 0; i < 20; i++) begin
      if (inst_valid && imem_req && !(busy && wait_cnt == 0)) break;
      cycle(0, 0, 0);
    end
    chk("rd_pre_valid", {31'd0, inst_valid}, 32'd1);
    stale = imem_addr;
    cycle(0, 1, 32'h0000_2003);
    chk("rd_flush", {31'd0, inst_valid}, 32'd0);
    chk("rd_stale_addr", imem_addr, stale);
    for (int i = 0; i < 10; i++) begin
      if (imem_addr != stale) break;
      cycle(1, 0, 0);
    end
    chk("rd_next_addr", imem_addr, 32'h0000_2000);
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) break;
      cycle(1, 0, 0);
    end
    chk("rd_first_pc", pc_out, 32'h0000_2000);

    // Simultaneous redirect, ack and pop
    lat_fixed = 0;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid && imem_req && !busy) break;
      cycle(1, 0, 0);
    end
    chk("sim_pre_valid", {31'd0, inst_valid}, 32'd1);
    cycle(1, 1, 32'h0000_3000);
    chk("sim_ack_acked", {31'd0, prev_ack}, 32'd1);
    chk("sim_flush", {31'd0, inst_valid}, 32'd0);
    chk("sim_addr", imem_addr, 32'h0000_3000);
    cycle(1, 0, 0);
    chk("sim_first_pc", pc_out, 32'h0000_3000);

    // Random traffic
    lat_rand = 1;
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
    end
    lat_rand = 0; lat_fixed = 0;

    // Wrap
    cycle(1, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 30; i++) begin
      if (inst_valid && pc_out == 32'hFFFF_FFFC) break;
      cycle(1, 0, 0);
    end
    chk("wrap_last", pc_out, 32'hFFFF_FFFC);
    cycle(1, 0, 0);
    chk("wrap_valid", {31'd0, inst_valid}, 32'd1);
    chk("wrap_zero", pc_out, 32'd0);

    // Reset mid-request
    lat_fixed = 10;
    repeat (3) cycle(1, 0, 0);
    chk("mr_req_before", {31'd0, imem_req}, 32'd1);
    #2;
    RST_N = 0;
    #1;
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    chk("mr_addr", imem_addr, RESET_PC);
    chk("mr_valid", {31'd0, inst_valid}, 32'd0);
    chk("mr_inst", INST, 32'd0);
    chk("mr_pc", pc_out, 32'd0);
    @(negedge CLK);
    mem_clear();
    lat_fixed = 0;
    exp_pc = RESET_PC;
    RST_N = 1;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) break;
      cycle(1, 0, 0);
    end
    chk("mr_restart_pc", pc_out, RESET_PC);
    repeat (5) cycle(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
